// File: rtl/loop_delay_meter_pkg.sv
// ---------------------------------------------------------------------------
// loop_delay_meter_pkg
//   Shared definitions for the loop delay meter: FSM state type, counter
//   width, saturation value and default probe parameters.
// ---------------------------------------------------------------------------
package loop_delay_meter_pkg;

    // Width of the shared settle/delay counter and of the reported delay.
    localparam int DELAY_W = 8;

    // Delay count at which a measurement gives up; the counter never wraps.
    localparam logic [DELAY_W-1:0] MAX_COUNT = 8'd255;

    // Default probe settings.
    localparam logic signed [15:0] DEF_PULSE_AMP     = 16'sd8192;
    localparam int                 DEF_PULSE_LEN     = 4;
    localparam int                 DEF_SETTLE_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        FIRE   = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/loop_delay_meter.sv
// ---------------------------------------------------------------------------
// loop_delay_meter
//   Measures the round-trip delay of an external loop (DAC -> ... -> ADC).
//   After a start request it waits until the return signal has stayed below
//   the threshold for SETTLE_CYCLES clocks, fires a PULSE_LEN-clock probe of
//   amplitude PULSE_AMP on data_o, and counts clocks until data_i reaches the
//   threshold. The count (0 = combinational loopback) is reported on delay_o;
//   if nothing arrives by count 255 the result saturates and timeout_o is set.
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous active-high reset
//   start_i    in   single-cycle measurement request (ignored while busy)
//   thr_i      in   signed 16-bit detection threshold
//   data_i     in   signed 16-bit loop return (ADC side)
//   data_o     out  signed 16-bit probe stimulus (DAC side), registered
//   delay_o    out  measured delay in clocks, held until the next result
//   done_o     out  one-cycle pulse when a measurement ends
//   timeout_o  out  last measurement saw no crossing, held until next result
//   busy_o     out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module loop_delay_meter
    import loop_delay_meter_pkg::*;
#(
    parameter logic signed [15:0] PULSE_AMP     = DEF_PULSE_AMP,
    parameter int                 PULSE_LEN     = DEF_PULSE_LEN,
    parameter int                 SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic signed [15:0]        thr_i,
    input  logic signed [15:0]        data_i,
    output logic signed [15:0]        data_o,
    output logic [DELAY_W-1:0]        delay_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic                      busy_o
);

    // Last counter values of the settle phase and of the probe pulse.
    localparam logic [DELAY_W-1:0] SETTLE_LAST = DELAY_W'(SETTLE_CYCLES - 1);
    localparam logic [DELAY_W-1:0] PULSE_LAST  = DELAY_W'(PULSE_LEN - 1);

    state_t                    state_reg,   state_next;
    logic [DELAY_W-1:0]        cnt_reg,     cnt_next;
    logic signed [15:0]        data_reg,    data_next;
    logic [DELAY_W-1:0]        delay_reg,   delay_next;
    logic                      timeout_reg, timeout_next;
    logic                      done_reg,    done_next;
    logic                      busy_reg,    busy_next;

    // Unregistered compare: a combinational loopback is seen in the same
    // clock the probe leaves, giving a delay of 0.
    logic hit;
    assign hit = (data_i >= thr_i);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        data_next    = '0;
        delay_next   = delay_reg;
        timeout_next = timeout_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end

            SETTLE: begin
                // The counter holds the number of consecutive quiet clocks
                // already seen; the current quiet clock completes the run.
                if (hit) begin
                    cnt_next = '0;
                end else if (cnt_reg == SETTLE_LAST) begin
                    state_next = FIRE;
                    cnt_next   = '0;
                    data_next  = PULSE_AMP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            FIRE, WAIT: begin
                if (hit) begin
                    state_next   = DONE;
                    delay_next   = cnt_reg;
                    timeout_next = 1'b0;
                    done_next    = 1'b1;
                end else if (cnt_reg == MAX_COUNT) begin
                    state_next   = DONE;
                    delay_next   = MAX_COUNT;
                    timeout_next = 1'b1;
                    done_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if ((state_reg == FIRE) && (cnt_reg != PULSE_LAST)) begin
                        data_next = PULSE_AMP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            data_reg    <= '0;
            delay_reg   <= '0;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            data_reg    <= data_next;
            delay_reg   <= delay_next;
            timeout_reg <= timeout_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
        end
    end

    assign data_o    = data_reg;
    assign delay_o   = delay_reg;
    assign done_o    = done_reg;
    assign timeout_o = timeout_reg;
    assign busy_o    = busy_reg;

endmodule

// File: tb/tb_loop_delay_meter.sv
// ---------------------------------------------------------------------------
// tb_loop_delay_meter
//   Drives the meter through an external delay line of selectable depth and
//   checks delay, timeout, done timing, pulse shape and reset behaviour
//   against expectations derived from the measurement rules.
// ---------------------------------------------------------------------------
module tb_loop_delay_meter;

    localparam int AMP    = 8192;
    localparam int PLEN   = 4;
    localparam int SETTLE = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] thr = 16'sd4096;
    logic signed [15:0] data_in;
    logic signed [15:0] data_out;
    logic [7:0]         delay;
    logic               done;
    logic               timeout;
    logic               busy;

    // Loop emulation controls.
    int                 dsel      = 0;
    bit                 zero_mode = 1'b0;
    bit                 ovr       = 1'b0;
    bit                 dl_clear  = 1'b0;
    logic signed [15:0] dl [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    loop_delay_meter dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .thr_i     (thr),
        .data_i    (data_in),
        .data_o    (data_out),
        .delay_o   (delay),
        .done_o    (done),
        .timeout_o (timeout),
        .busy_o    (busy)
    );

    // External delay line: dl[k] holds data_o from k+1 clocks ago.
    always @(posedge clk) begin
        if (dl_clear) begin
            for (int i = 0; i < 256; i++) dl[i] <= '0;
        end else begin
            dl[0] <= data_out;
            for (int i = 1; i < 256; i++) dl[i] <= dl[i-1];
        end
    end

    always_comb begin
        if (ovr)            data_in = 16'sd5000;
        else if (zero_mode) data_in = '0;
        else if (dsel == 0) data_in = data_out;
        else                data_in = dl[dsel-1];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One measurement. d = loop delay, hold = clocks of forced 5000 on data_i
    // right after start, spam = random start pulses while busy and on the
    // DONE cycle, to_mode = data_i tied to zero (no crossing).
    task automatic run_measure(input int d, input int hold, input bit spam,
                               input bit to_mode);
        int exp_delay, exp_to, lat, exp_pulses, exp_first;
        int pulses, dones, done_at, first_at;
        exp_delay  = to_mode ? 255 : d;
        exp_to     = to_mode ? 1 : 0;
        lat        = hold + SETTLE + 1 + exp_delay;
        exp_first  = hold + SETTLE;
        exp_pulses = (to_mode || d + 1 > PLEN) ? PLEN : d + 1;
        pulses = 0; dones = 0; done_at = -1; first_at = -1;

        dsel = d; zero_mode = to_mode;
        dl_clear = 1'b1;
        @(posedge clk); #1;
        dl_clear = 1'b0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= lat + 4; n++) begin
            ovr   = (n <= hold);
            start = (spam && n <= lat + 1) ? 1'($urandom % 2) : 1'b0;
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = n;
            end
            if (int'(data_out) == AMP) begin
                pulses++;
                if (first_at < 0) first_at = n;
            end
        end
        start = 1'b0; ovr = 1'b0;

        $display("run d=%0d hold=%0d spam=%0d to=%0d: delay=%0d timeout=%0d done_at=%0d pulses=%0d",
                 d, hold, spam, to_mode, delay, timeout, done_at, pulses);
        chk("delay", int'(delay), exp_delay);
        chk("timeout", int'(timeout), exp_to);
        chk("done_count", dones, 1);
        chk("done_cycle", done_at, lat);
        chk("pulse_first", first_at, exp_first);
        chk("pulse_len", pulses, exp_pulses);
        chk("idle_after", int'(busy), 0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(data_out), 0);
        chk("rst_delay", int'(delay), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed: loop of 10, combinational loopback, one register.
        run_measure(10, 0, 1'b0, 1'b0);
        run_measure(0, 0, 1'b0, 1'b0);
        run_measure(1, 0, 1'b0, 1'b0);
        // No crossing: saturate at 255 with timeout.
        run_measure(0, 0, 1'b0, 1'b1);
        // Return held high for 40 clocks delays the settle phase.
        run_measure(3, 40, 1'b0, 1'b0);
        // Repeated start requests while busy and on the DONE cycle.
        run_measure(7, 0, 1'b1, 1'b0);
        run_measure(2, 0, 1'b1, 1'b0);

        // Randomized loop delays, thresholds and start spamming.
        for (int r = 0; r < 10; r++) begin
            thr = 16'($urandom_range(1, 8192));
            run_measure(int'($urandom_range(0, 60)), 0, 1'($urandom % 2), 1'b0);
        end
        thr = 16'sd4096;

        // Reset during WAIT aborts the run without a done pulse.
        run_measure(10, 0, 1'b0, 1'b0);
        begin
            int dones;
            dones = 0;
            dsel = 30; zero_mode = 1'b0;
            dl_clear = 1'b1;
            @(posedge clk); #1;
            dl_clear = 1'b0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int n = 1; n <= SETTLE + 1 + PLEN + 5; n++) begin
                @(posedge clk); #1;
                if (done) dones++;
            end
            chk("pre_rst_busy", int'(busy), 1);
            rst = 1'b1;
            #1;
            chk("abort_data", int'(data_out), 0);
            chk("abort_delay", int'(delay), 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_timeout", int'(timeout), 0);
            for (int n = 0; n < 3; n++) begin
                @(posedge clk); #1;
                if (done) dones++;
            end
            rst = 1'b0;
            for (int n = 0; n < 40; n++) begin
                @(posedge clk); #1;
                if (done) dones++;
            end
            $display("abort: done pulses during aborted run=%0d", dones);
            chk("abort_no_done", dones, 0);
        end
        run_measure(3, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
